// File: rtl/if_fetch_queue.sv
// Fetch stage: sequential PC generation, single-outstanding imem read handshake,
// and a QDEPTH-entry instruction queue feeding decode over valid/ready.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     QDEPTH   = 4,
  parameter int unsigned     PC_STEP  = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_npc,
  output logic [XLEN-1:0] fetch_pc
);

  localparam int unsigned     PtrW       = $clog2(QDEPTH);
  localparam int unsigned     CntW       = $clog2(QDEPTH + 1);
  localparam logic [CntW-1:0] Full       = CntW'(QDEPTH);
  localparam logic [CntW-1:0] AlmostFull = CntW'(QDEPTH - 1);
  localparam logic [XLEN-1:0] Step       = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] q_pc    [QDEPTH];
  logic [XLEN-1:0] q_instr [QDEPTH];

  logic rsp, can_issue, issue, push, pop, not_empty;

  assign fetch_pc  = fetch_pc_q;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    rsp       = outstanding_q && imem_rvalid;
    not_empty = (count_q != '0);
    // A response arriving this cycle frees the single outstanding slot, but a
    // non-dropped one also consumes a queue entry.
    can_issue = (!outstanding_q && (count_q < Full)) ||
                (rsp && !drop_q && (count_q < AlmostFull)) ||
                (rsp && drop_q && (count_q < Full));
    imem_req  = can_issue && !redirect_valid;
    issue     = imem_req && imem_gnt;
    id_valid  = not_empty && !redirect_valid;
    pop       = id_valid && id_ready;
    push      = rsp && !drop_q && !redirect_valid;

    id_instr = not_empty ? q_instr[rd_ptr_q] : '0;
    id_pc    = not_empty ? q_pc[rd_ptr_q] : '0;
    id_npc   = not_empty ? q_pc[rd_ptr_q] + Step : '0;

    fetch_pc_d    = fetch_pc_q;
    tag_pc_d      = tag_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // A pending response belongs to the old path and must be swallowed.
      outstanding_d = outstanding_q && !imem_rvalid;
      drop_d        = outstanding_q && !imem_rvalid;
    end else begin
      if (rsp) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
      if (issue) begin
        outstanding_d = 1'b1;
        tag_pc_d      = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + Step;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      tag_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      tag_pc_q      <= tag_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q_pc[wr_ptr_q]    <= tag_pc_q;
      q_instr[wr_ptr_q] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= Full);
      assert (!(push && (count_q == Full)));
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue: queue-based reference model checked every
// cycle, plus directed scenarios pinned with literal expectations.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr, id_pc, id_npc, fetch_pc;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_npc        (id_npc),
    .fetch_pc      (fetch_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: what the fetch stage must look like architecturally
  ent_t        mq[$];
  logic [31:0] m_fpc = '0;
  logic [31:0] m_tag = '0;
  bit          m_out = 0;
  bit          m_drop = 0;

  // Memory model
  bit          mp = 0;
  int          mrem = 0;
  logic [31:0] maddr = '0;

  // Stimulus knobs
  int          lat = 1, gnt_pct = 0, ready_pct = 100, stray_pct = 0, rredir_pct = 0;
  bit          rst_k = 1;
  int          redir_mode = 0;  // 0 none, 1 next cycle, 2 on rvalid, 3 on req && !gnt
  logic [31:0] redir_target = '0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_can(input bit rv);
    int c = mq.size();
    return (!m_out && c < 4) || (m_out && rv && !m_drop && c < 3) ||
           (m_out && rv && m_drop && c < 4);
  endfunction

  task automatic step();
    bit          rv, gnt, rd, e_req, e_valid;
    logic [31:0] rdata, tgt;
    ent_t        h;
    @(posedge clk);
    #1;
    reset = rst_k;
    rv    = 0;
    rdata = $urandom;
    if (mp) begin
      mrem--;
      if (mrem == 0) begin
        rv    = 1;
        rdata = 32'hA000_0000 + maddr;
        mp    = 0;
      end
    end else if ($urandom_range(99) < stray_pct) begin
      rv = 1;
    end
    gnt = !mp && ($urandom_range(99) < gnt_pct);
    imem_rvalid = rv;
    imem_rdata  = rdata;
    imem_gnt    = gnt;
    id_ready    = ($urandom_range(99) < ready_pct);
    rd  = 0;
    tgt = $urandom;
    case (redir_mode)
      1: rd = 1;
      2: rd = rv && m_out;
      3: rd = m_can(rv) && !gnt && !rst_k;
      default: rd = 0;
    endcase
    if (rd) begin
      tgt        = redir_target;
      redir_mode = 0;
    end else if ($urandom_range(99) < rredir_pct) begin
      rd = 1;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFFC + 32'($urandom_range(3));
    end
    redirect_valid = rd;
    redirect_pc    = tgt;

    @(negedge clk);
    e_req   = m_can(rv) && !rd;
    e_valid = (mq.size() != 0) && !rd;
    h       = (mq.size() != 0) ? mq[0] : '0;
    if (!rst_k) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("imem_addr", imem_addr, m_fpc);
      chk("fetch_pc", fetch_pc, m_fpc);
      chk("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
      chk("id_pc", id_pc, h.pc);
      chk("id_instr", id_instr, h.instr);
      chk("id_npc", id_npc, (mq.size() != 0) ? h.pc + 32'd1 : 32'd0);
    end
    if (imem_req === 1'b1 && gnt) begin
      mp    = 1;
      mrem  = lat;
      maddr = imem_addr;
    end
    if (rst_k) begin
      mq.delete();
      m_fpc  = '0;
      m_out  = 0;
      m_drop = 0;
    end else if (rd) begin
      mq.delete();
      m_fpc  = tgt;
      m_drop = m_out && !rv;
      m_out  = m_out && !rv;
    end else begin
      if (e_valid && id_ready) void'(mq.pop_front());
      if (m_out && rv) begin
        if (!m_drop) mq.push_back('{pc: m_tag, instr: rdata});
        m_out  = 0;
        m_drop = 0;
      end
      if (e_req && gnt) begin
        m_out = 1;
        m_tag = m_fpc;
        m_fpc = m_fpc + 32'd1;
      end
    end
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int k = 0;
    do begin
      step();
      k++;
    end while (id_valid !== 1'b1 && k < lim);
    if (id_valid !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: id_valid never rose within %0d cycles", nm, lim);
    end
  endtask

  task automatic fire_redirect(input int mode, input logic [31:0] tgt);
    int k = 0;
    redir_mode   = mode;
    redir_target = tgt;
    while (redir_mode != 0 && k < 40) begin
      step();
      k++;
    end
    if (redir_mode != 0) begin
      redir_mode = 0;
      n_vec++;
      n_err++;
      $display("FAIL redirect_arm: mode %0d never triggered", mode);
    end
  endtask

  task automatic wait_inflight();
    int k = 0;
    while (!(m_out && mp && mrem >= 2) && k < 30) begin
      step();
      k++;
    end
  endtask

  initial begin
    // Reset, then 1-cycle memory streaming into an always-ready decoder
    repeat (2) step();
    rst_k   = 0;
    gnt_pct = 100;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k >= 2 && k <= 5) begin
        chk("seq_valid", {31'b0, id_valid}, 32'd1);
        chk("seq_pc", id_pc, 32'(k - 2));
        chk("seq_npc", id_npc, 32'(k - 1));
        chk("seq_instr", id_instr, 32'hA000_0000 + 32'(k - 2));
      end
    end

    // Decode stall fills the queue, then drains in order
    ready_pct = 0;
    repeat (10) step();
    chk("full_req", {31'b0, imem_req}, 32'd0);
    chk("full_head", id_pc, 32'd6);
    chk("model_depth", 32'(mq.size()), 32'd4);
    ready_pct = 100;
    repeat (12) step();

    // Redirect while a 3-cycle read is in flight
    lat = 3;
    wait_inflight();
    fire_redirect(1, 32'h40);
    wait_valid("redir_inflight", 40);
    chk("redir_pc", id_pc, 32'h40);
    chk("redir_instr", id_instr, 32'hA000_0040);

    // Redirect coinciding with rvalid
    lat = 2;
    repeat (3) step();
    fire_redirect(2, 32'h80);
    wait_valid("redir_rvalid", 40);
    chk("redir_rv_pc", id_pc, 32'h80);

    // Redirect while req is waiting for gnt
    gnt_pct = 0;
    fire_redirect(3, 32'hC0);
    step();
    chk("redir_gnt_addr", imem_addr, 32'hC0);
    gnt_pct = 100;
    wait_valid("redir_gnt", 40);
    chk("redir_gnt_pc", id_pc, 32'hC0);

    // Grant stall holds the request address
    lat     = 1;
    gnt_pct = 0;
    fire_redirect(1, 32'h100);
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h100);
      chk("stall_fpc", fetch_pc, 32'h100);
    end
    gnt_pct = 100;
    wait_valid("stall_release", 20);
    chk("stall_pc", id_pc, 32'h100);

    // Reset with a read in flight; late rvalid must be ignored
    lat = 3;
    wait_inflight();
    rst_k = 1;
    step();
    rst_k = 0;
    step();
    chk("rst_fpc", fetch_pc, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    wait_valid("rst_restart", 40);
    chk("rst_pc", id_pc, 32'd0);

    // PC wrap
    lat = 1;
    fire_redirect(1, 32'hFFFF_FFFE);
    wait_valid("wrap", 20);
    chk("wrap_pc0", id_pc, 32'hFFFF_FFFE);
    step();
    chk("wrap_pc1", id_pc, 32'hFFFF_FFFF);
    chk("wrap_npc1", id_npc, 32'd0);
    step();
    chk("wrap_pc2", id_pc, 32'd0);

    // Randomised traffic
    stray_pct  = 10;
    rredir_pct = 3;
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) begin
        lat       = $urandom_range(4, 1);
        gnt_pct   = $urandom_range(100, 30);
        ready_pct = $urandom_range(100, 20);
      end
      rst_k = ($urandom_range(999) < 5);
      step();
    end
    rst_k = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
